// File: rtl/xbar_slave_arb_if.sv
// Request/grant bundle between the per-master address decode, the
// arbiter that owns one crossbar slave port, and the slave-side mux.
//   master : requester side (drives requests and the slave ack)
//   slave  : arbiter side (xbar_slave_arb connects here)
interface xbar_slave_arb_if #(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
);
   logic [NUM_MASTERS-1:0] m_req;
   logic                   s_ack;
   logic [NUM_MASTERS-1:0] grant;
   logic [IDX_W-1:0]       grant_idx;
   logic                   busy;
   logic                   s_req;
   logic                   timeout_err;

   modport master (
      output m_req, s_ack,
      input  grant, grant_idx, busy, s_req, timeout_err
   );

   modport slave (
      input  m_req, s_ack,
      output grant, grant_idx, busy, s_req, timeout_err
   );
endinterface

// File: rtl/xbar_slave_arb.sv
// Registered round-robin arbiter for one crossbar slave port.
// The grant is held for a whole req/ack transaction and then moves to the
// next requester after the one just served, so no master can starve.
// Optional build macro XBAR_ARB_TIMEOUT_EN adds a wait counter that revokes
// a grant left waiting TIMEOUT cycles for s_ack and pulses timeout_err.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant; first requester after 'last' is granted next edge
//   OWNED | one master holds the slave until ack, abort or timeout
module xbar_slave_arb #(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS),
   parameter int TIMEOUT     = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   xbar_slave_arb_if.slave bus
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic                   terr_q, terr_d;
   logic                   tmo;
   logic                   owner_req;

   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       scan_idx;
   logic [NUM_MASTERS-1:0] cand;
   logic                   pick_found;

   // Out-of-range parameters are rejected at elaboration.
   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("xbar_slave_arb: parameter out of range");
   end

   assign owner_req = |(grant_q & bus.m_req);

`ifdef XBAR_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   assign tmo = (state_q == OWNED) && !bus.s_ack && (cnt_q == 8'(TIMEOUT - 1));

   // Wait counter: cleared on each new grant, counts OWNED cycles without ack.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   // Round-robin search: first candidate after ptr, wrapping modulo NUM_MASTERS.
   // After a completion the pointer is the master just served and its own
   // request is masked out for that cycle.
   always_comb begin
      ptr        = (state_q == OWNED) ? idx_q : last_q;
      cand       = (state_q == OWNED) ? (bus.m_req & ~grant_q) : bus.m_req;
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         scan_idx = IDX_W'((int'(ptr) + i) % NUM_MASTERS);
         if (!pick_found && cand[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Next-state and next-grant decision.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      last_d  = last_q;
      terr_d  = 1'b0;
`ifdef XBAR_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWNED;
               grant_d = NUM_MASTERS'(1) << pick_idx;
               idx_d   = pick_idx;
`ifdef XBAR_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         OWNED: begin
            if (bus.s_ack || tmo) begin
               // Completion (or revocation): record the served master and
               // hand over back-to-back if anyone else is waiting.
               last_d = idx_q;
               terr_d = tmo;
               if (pick_found) begin
                  grant_d = NUM_MASTERS'(1) << pick_idx;
                  idx_d   = pick_idx;
`ifdef XBAR_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (!owner_req) begin
               // Abort: the owner withdrew without completing; 'last' is kept.
               state_d = IDLE;
               grant_d = '0;
            end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and priority-pointer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         terr_q  <= terr_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.busy        = (state_q == OWNED);
   assign bus.s_req       = owner_req;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_xbar_slave_arb.sv
// Bench for xbar_slave_arb: a 2-master instance (TIMEOUT=4) and a 4-master
// instance run against an owner/last reference model, plus directed checks.
module tb_xbar_slave_arb;

`ifdef XBAR_ARB_TIMEOUT_EN
   localparam int TMO_EN = 1;
`else
   localparam int TMO_EN = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xbar_slave_arb_if #(.NUM_MASTERS(2)) bus2 ();
   xbar_slave_arb_if #(.NUM_MASTERS(4)) bus4 ();

   xbar_slave_arb #(.NUM_MASTERS(2), .TIMEOUT(4)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   xbar_slave_arb #(.NUM_MASTERS(4), .TIMEOUT(16)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // owner = -1 means nobody holds the slave
   typedef struct packed {
      int   owner;
      int   last;
      int   idx;
      int   waited;
      logic terr;
   } mdl_t;

   mdl_t m2, m4;

   function automatic int first_after(int req, int from, int n);
      for (int k = 1; k <= n; k++) begin
         if (req[(from + k) % n]) return (from + k) % n;
      end
      return -1;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int n, int req, bit ack, bit rstn, int tmo);
      mdl_t r;
      int   nxt;
      bit   expired;
      r      = s;
      r.terr = 1'b0;
      if (!rstn) begin
         r.owner = -1; r.last = n - 1; r.idx = 0; r.waited = 0;
         return r;
      end
      if (s.owner < 0) begin
         nxt = first_after(req, s.last, n);
         if (nxt >= 0) begin r.owner = nxt; r.idx = nxt; r.waited = 0; end
      end else begin
         expired = (TMO_EN != 0) && !ack && (s.waited == tmo - 1);
         if (ack || expired) begin
            r.last = s.owner;
            r.terr = expired;
            nxt = first_after(req & ~(1 << s.owner), s.owner, n);
            if (nxt >= 0) begin r.owner = nxt; r.idx = nxt; r.waited = 0; end
            else r.owner = -1;
         end else if (!req[s.owner]) begin
            r.owner = -1;
         end else begin
            r.waited = s.waited + 1;
         end
      end
      return r;
   endfunction

   function automatic int mgrant(mdl_t s);
      return (s.owner < 0) ? 0 : (1 << s.owner);
   endfunction

   function automatic int msreq(mdl_t s, int req);
      return (s.owner >= 0 && req[s.owner]) ? 1 : 0;
   endfunction

   task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   initial begin
      m2 = '{owner: -1, last: 1, idx: 0, waited: 0, terr: 1'b0};
      m4 = '{owner: -1, last: 3, idx: 0, waited: 0, terr: 1'b0};
   end

   // Model advances on the same edge the DUT samples its inputs.
   always @(posedge clk) begin
      m2 = mstep(m2, 2, int'(bus2.m_req), bus2.s_ack, rst_n, 4);
      m4 = mstep(m4, 4, int'(bus4.m_req), bus4.s_ack, rst_n, 16);
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m2_grant", 8'(bus2.grant),       8'(mgrant(m2)));
         cmp("m2_idx",   8'(bus2.grant_idx),   8'(m2.idx));
         cmp("m2_busy",  8'(bus2.busy),        8'(m2.owner >= 0));
         cmp("m2_sreq",  8'(bus2.s_req),       8'(msreq(m2, int'(bus2.m_req))));
         cmp("m2_terr",  8'(bus2.timeout_err), 8'(m2.terr));
         cmp("m4_grant", 8'(bus4.grant),       8'(mgrant(m4)));
         cmp("m4_idx",   8'(bus4.grant_idx),   8'(m4.idx));
         cmp("m4_busy",  8'(bus4.busy),        8'(m4.owner >= 0));
         cmp("m4_sreq",  8'(bus4.s_req),       8'(msreq(m4, int'(bus4.m_req))));
         cmp("m4_terr",  8'(bus4.timeout_err), 8'(m4.terr));
      end
   end

   // One clock: advance past the next negedge, then settle before driving.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk2(input string name, input logic [1:0] g, input logic b);
      cmp({name, "_grant"}, 8'(bus2.grant), 8'(g));
      cmp({name, "_busy"},  8'(bus2.busy),  8'(b));
   endtask

   initial begin
      bus2.m_req = '0; bus2.s_ack = 1'b0;
      bus4.m_req = '0; bus4.s_ack = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      chk2("reset", 2'b00, 1'b0);
      cmp("reset_idx",  8'(bus2.grant_idx),   8'h00);
      cmp("reset_terr", 8'(bus2.timeout_err), 8'h00);
      rst_n = 1'b1;

      // Request from both: master 0 first, then back-to-back to master 1.
      bus2.m_req = 2'b11;
      step();
      chk2("first_grant", 2'b01, 1'b1);
      cmp("first_sreq", 8'(bus2.s_req), 8'h01);
      bus2.s_ack = 1'b1;
      step();
      chk2("ack_handover", 2'b10, 1'b1);
      cmp("ack_handover_idx", 8'(bus2.grant_idx), 8'h01);

      // Continuous requests and acks: strict alternation, busy stays high.
      for (int i = 0; i < 4; i++) begin
         step();
         chk2($sformatf("alt%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      end

      // Master 1 holds; it drops its request without an ack -> abort.
      bus2.s_ack = 1'b0;
      bus2.m_req = 2'b01;
      step();
      chk2("abort", 2'b00, 1'b0);
      cmp("abort_idx_held", 8'(bus2.grant_idx), 8'h01);
      bus2.m_req = 2'b11;
      step();
      chk2("after_abort", 2'b10, 1'b1);

      // Four masters: set last=1, then 1010 -> 1000, then wrap to 0001.
      bus4.m_req = 4'b0010;
      step();
      cmp("m4_g1", 8'(bus4.grant), 8'h02);
      bus4.s_ack = 1'b1;
      bus4.m_req = 4'b1010;
      step();
      cmp("m4_g3", 8'(bus4.grant), 8'h08);
      bus4.m_req = 4'b1011;
      step();
      cmp("m4_wrap", 8'(bus4.grant), 8'h01);
      cmp("m4_wrap_idx", 8'(bus4.grant_idx), 8'h00);
      bus4.s_ack = 1'b0;
      bus4.m_req = 4'b0000;
      step();
      cmp("m4_idle", 8'(bus4.grant), 8'h00);

      // Reset while master 1 owns the slave.
      rst_n = 1'b0;
      step();
      chk2("mid_reset", 2'b00, 1'b0);
      cmp("mid_reset_idx", 8'(bus2.grant_idx), 8'h00);
      rst_n = 1'b1;
      step();
      chk2("post_reset", 2'b01, 1'b1);

      // Ack with nobody else waiting -> idle; an ack while idle is ignored.
      bus2.m_req = 2'b00;
      bus2.s_ack = 1'b1;
      step();
      chk2("ack_to_idle", 2'b00, 1'b0);
      step();
      chk2("idle_ack_ignored", 2'b00, 1'b0);
      bus2.s_ack = 1'b0;

      // Master 0 granted; master 1 arrives and must not disturb the grant.
      bus2.m_req = 2'b01;
      step();
      chk2("hold_start", 2'b01, 1'b1);
      bus2.m_req = 2'b11;
      step();
      step();
      step();
      chk2("hold_4th_cycle", 2'b01, 1'b1);
      step();
`ifdef XBAR_ARB_TIMEOUT_EN
      chk2("timeout_revoke", 2'b10, 1'b1);
      cmp("timeout_pulse", 8'(bus2.timeout_err), 8'h01);
      step();
      cmp("timeout_pulse_end", 8'(bus2.timeout_err), 8'h00);
`else
      chk2("no_timeout", 2'b01, 1'b1);
      cmp("no_timeout_err", 8'(bus2.timeout_err), 8'h00);
`endif

      bus2.m_req = 2'b00;
      step();
      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/xbar_slave_arb.md
# xbar_slave_arb

Registered round-robin arbiter that shares one crossbar slave port between `NUM_MASTERS` requesting masters. It sits between the per-master address decode (which produces one request bit per master for this slave) and the slave-side data mux. Its one-hot grant drives the mux select and the ack/rdata return steering. The grant is held for the whole req/ack transaction and moves fairly on completion, so a master can never be starved.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of requesters; legal range 2..8.
- `IDX_W`, `$clog2(NUM_MASTERS)`, width of `grant_idx`.
- `TIMEOUT`, 16, number of cycles a grant may wait for `s_ack` before it is revoked. Used only with `XBAR_ARB_TIMEOUT_EN`. Legal range 2..255.

Ports. Clock is `clk`; reset is synchronous and active-low, named `rst_n`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `m_req`  in  NUM_MASTERS  per-master request for this slave, already address-decoded.
- `s_ack`  in  1  slave acknowledge; a one-cycle pulse completes the current transaction.
- `grant`  out  NUM_MASTERS  registered one-hot grant; all zero when idle.
- `grant_idx`  out  IDX_W  binary index of the granted master; holds its last value when idle.
- `busy`  out  1  registered; high while any grant is active.
- `s_req`  out  1  combinational; equals `|(grant & m_req)`.
- `timeout_err`  out  1  registered one-cycle pulse when a grant is revoked by timeout; tied 0 when the feature is compiled out.

## Operation
- States: IDLE and OWNED. `busy` is 1 exactly when the state is OWNED.
- Priority pointer `last` (IDX_W bits) records the most recently served master. Search order is `last+1`, `last+2`, … wrapping modulo NUM_MASTERS.
- IDLE:
  - Any `m_req` bit high → the first requester in search order is granted; state goes to OWNED.
  - No request → stay in IDLE; `grant` stays 0.
- OWNED, with master g granted:
  - `s_ack`=1 → transaction completes and `last`←g.
    - The candidate set for the next grant is `m_req & ~(1<<g)`; g's own request is masked during its ack cycle.
    - Non-empty candidate set → grant the next requester in search order from the updated `last`, back-to-back, with no idle cycle.
    - Empty candidate set → go to IDLE.
  - `s_ack`=0 and `m_req[g]`=0 → master aborted; go to IDLE. `last` is not updated.
  - Otherwise → hold the grant unchanged.
- Only one grant bit is ever high. `grant_idx` always matches `grant` while `busy` is high.
- Requests from non-granted masters never disturb the current grant.
- `s_ack` received while in IDLE is ignored.
- Reset values: `grant`=0, `grant_idx`=0, `busy`=0, `timeout_err`=0, state=IDLE. `last` resets to NUM_MASTERS-1, so master 0 has the highest priority first.
- Reset asserted mid-transaction: all of the above values are restored at the next edge. No completion is recorded.

## Timing
- Request-to-grant latency is one cycle: `m_req` high before edge k → `grant` valid after edge k.
- Ack-to-release latency is one cycle: `s_ack` sampled at edge k → new grant, or zero grant, visible after edge k.
- `s_req` follows `m_req` of the granted master combinationally, with zero added latency.
- Maximum throughput is one transaction per cycle per slave, provided the slave acks in the grant cycle.
- Simultaneous `s_ack` and abort: `s_ack` wins and the cycle counts as a completion.

## Configuration
- `XBAR_ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on every new grant and increments each OWNED cycle without `s_ack`.
  - When the counter reaches TIMEOUT-1 with no ack, at the next edge: the grant is revoked, `last`←g, `timeout_err` pulses for one cycle, and the next requester (excluding g) is granted exactly as for a completion.
- Not defined: no counter exists, a grant is held indefinitely, and `timeout_err` is constant 0.

## Test plan
- After reset, `m_req`=2'b11 → `grant`=2'b01 after 1 cycle; `s_ack` pulse → `grant`=2'b10 on the next cycle, with no IDLE gap.
- Both masters request continuously and the slave acks every cycle → `grant` alternates 01,10,01,10 and `busy` stays 1.
- With master 1 granted, drop `m_req[1]` without an ack → `grant`=0 and `busy`=0 next cycle; then `m_req`=2'b11 → `grant`=2'b10, because `last` was not updated by the abort.
- NUM_MASTERS=4, `m_req`=4'b1010, `last`=1 → grant 4'b1000; on ack with `m_req`=4'b1011 → grant 4'b0001 (wrap-around).
- Assert `rst_n`=0 for one cycle while a grant is active → all outputs 0 after the edge; `m_req`=2'b11 then → `grant`=2'b01.
- With `XBAR_ARB_TIMEOUT_EN` and TIMEOUT=4, master 0 granted with no ack and master 1 requesting → after 4 OWNED cycles `timeout_err`=1 for one cycle and `grant`=2'b10.
